// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, grant encoding,
// default bus widths and the priority rule used in the idle cycle.
package cpu_mem_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DM} grant_e;

  // Data port wins unless fetch has been passed over too many times in a row.
  function automatic grant_e pick_grant(input logic if_req, input logic dm_req,
                                        input logic force_if);
    if (dm_req && !(if_req && force_if)) return GNT_DM;
    else if (if_req)                     return GNT_IF;
    else                                 return GNT_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive data grants made while a fetch was waiting;
// force_if tells the arbiter to let the fetch through next.
module mem_arb_starve
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               dm_grant,
  input  logic                               if_grant,
  input  logic                               if_req,
  input  logic                               idle,
  output logic                               force_if,
  output logic [$clog2(STARVE_MAX+1)-1:0]    count
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  // An idle cycle without a pending fetch means nobody is being starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (if_grant || (idle && !if_req)) begin
      count <= '0;
    end else if (dm_grant && if_req && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  assign force_if = (count == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports of the
// pipeline: IDLE picks a port, ACCESS waits for mem_ready, DONE pulses the ack.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_e state;
  grant_e grant;
  grant_e gnt_sel;
  logic   idle;
  logic   force_if;
  logic [$clog2(STARVE_MAX+1)-1:0] starve_cnt;

  assign idle    = (state == ST_IDLE);
  assign gnt_sel = pick_grant(if_req, dm_req, force_if);

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .dm_grant (idle && (gnt_sel == GNT_DM)),
    .if_grant (idle && (gnt_sel == GNT_IF)),
    .if_req   (if_req),
    .idle     (idle),
    .force_if (force_if),
    .count    (starve_cnt)
  );

  always @(posedge clk) begin
    if (rst_n) assert (int'(starve_cnt) <= STARVE_MAX);
  end

  // Requests are only looked at in IDLE, so a req still held during DONE is
  // never granted twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= GNT_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_sel != GNT_NONE) begin
            grant  <= gnt_sel;
            mem_en <= 1'b1;
            state  <= ST_ACCESS;
            if (gnt_sel == GNT_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            // Writes leave the data port's read register untouched.
            if (!mem_we) begin
              if (grant == GNT_DM) dm_rdata <= mem_rdata;
              else                 if_rdata <= mem_rdata;
            end
            if_ack <= (grant == GNT_IF);
            dm_ack <= (grant == GNT_DM);
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          grant  <= GNT_NONE;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requester processes push expected read data, a monitor
// pops on each ack and checks data, grant order and stall behaviour.
module tb_mem_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          stall_if;
  logic          stall_mem;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } job_t;

  int            checks = 0;
  int            failures = 0;
  job_t          if_jobs[$];
  job_t          dm_jobs[$];
  logic [DW-1:0] if_exp[$];
  logic [DW-1:0] dm_exp[$];
  int            grant_exp[$];     // 1 = fetch, 2 = data
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] dev_mem [128];
  int            fixed_wait = 0;   // <0 selects random wait states
  int            reset_epoch = 0;
  bit            if_busy = 1'b0;
  bit            dm_busy = 1'b0;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5)  return 32'h8C22_0010;
    if (a == 32) return 32'h0000_1234;
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Memory device: holds mem_ready low for the chosen number of wait cycles.
  initial begin : responder
    int wait_left;
    bit armed;
    wait_left = 0;
    armed = 1'b0;
    for (int i = 0; i < 128; i++) dev_mem[i] = init_word(i);
    forever begin
      @(negedge clk); #2;
      if (rst_n !== 1'b1 || !mem_en) begin
        mem_ready = 1'b0;
        armed = 1'b0;
      end else begin
        if (!armed) begin
          armed = 1'b1;
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = dev_mem[mem_addr];
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
        end else begin
          wait_left--;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : fetch_requester
    job_t j;
    int n;
    forever begin
      @(negedge clk); #2;
      while (if_jobs.size() > 0) begin
        if_busy = 1'b1;
        j = if_jobs.pop_front();
        if_addr = j.addr;
        if_req = 1'b1;
        if_exp.push_back(ref_mem[j.addr]);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!if_ack && n < 300);
        if (!if_ack) fail("if_ack_timeout", "no fetch ack within 300 cycles");
      end
      if_req = 1'b0;
      if_busy = 1'b0;
    end
  end

  initial begin : data_requester
    job_t j;
    int n;
    int my_epoch;
    logic [DW-1:0] last_dm;
    my_epoch = 0;
    last_dm = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk); #2;
      while (dm_jobs.size() > 0) begin
        dm_busy = 1'b1;
        j = dm_jobs.pop_front();
        if (my_epoch != reset_epoch) begin
          last_dm = '0;
          my_epoch = reset_epoch;
        end
        if (j.we) ref_mem[j.addr] = j.wdata;
        else      last_dm = ref_mem[j.addr];
        dm_exp.push_back(last_dm);
        dm_we = j.we;
        dm_addr = j.addr;
        dm_wdata = j.wdata;
        dm_req = 1'b1;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!dm_ack && n < 300);
        if (!dm_ack) fail("dm_ack_timeout", "no data ack within 300 cycles");
      end
      dm_req = 1'b0;
      dm_busy = 1'b0;
    end
  end

  task automatic check_grant(input int port);
    int e;
    if (grant_exp.size() == 0) begin
      fail("grant_order", $sformatf("ack on port %0d with no grant expected", port));
    end else begin
      e = grant_exp.pop_front();
      checks++;
      if (e != port) begin
        failures++;
        $display("FAIL grant_order: got port %0d, expected port %0d", port, e);
      end
    end
  endtask

  // Monitor: checks every ack against the queues; predicts each grant from
  // the request lines seen during an idle cycle and the starvation rule.
  initial begin : monitor
    int  cnt;
    bit  prev_en;
    bit  prev_ack;
    cnt = 0;
    prev_en = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst_n !== 1'b1) begin
        grant_exp.delete();
        cnt = 0;
        prev_en = 1'b0;
        prev_ack = 1'b0;
        continue;
      end
      check1("stall_if", stall_if, if_req & ~if_ack);
      check1("stall_mem", stall_mem, dm_req & ~dm_ack);
      if (if_ack && dm_ack) fail("ack_exclusive", "if_ack and dm_ack both high");
      if (mem_en && !prev_en) check1("no_grant_in_done", prev_ack, 1'b0);
      if (if_ack) begin
        if (if_exp.size() == 0) fail("if_ack_unexpected", "fetch ack with nothing outstanding");
        else check("if_rdata", if_rdata, if_exp.pop_front());
        check_grant(1);
      end
      if (dm_ack) begin
        if (dm_exp.size() == 0) fail("dm_ack_unexpected", "data ack with nothing outstanding");
        else check("dm_rdata", dm_rdata, dm_exp.pop_front());
        check_grant(2);
      end
      prev_en = mem_en;
      prev_ack = if_ack | dm_ack;
      #2;
      if (rst_n === 1'b1 && !mem_en && !if_ack && !dm_ack) begin
        if (dm_req && (!if_req || cnt < SM)) begin
          grant_exp.push_back(2);
          cnt = if_req ? cnt + 1 : 0;
        end else if (if_req) begin
          grant_exp.push_back(1);
          cnt = 0;
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic push_job(input int port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    job_t j;
    j.we = we;
    j.addr = addr;
    j.wdata = wdata;
    if (port == 1) if_jobs.push_back(j);
    else           dm_jobs.push_back(j);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if_busy || dm_busy || if_jobs.size() > 0 || dm_jobs.size() > 0) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 3000) fail("idle_timeout", "requesters still busy after 3000 cycles");
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Follows one isolated access from the idle cycle through its ack cycle.
  task automatic watch_access(input int port, input logic [AW-1:0] addr, input logic we,
                              input logic [DW-1:0] wdata, input int cycles);
    int n = 0;
    int a = 0;
    logic prev = 1'b0;
    #2;
    do begin
      prev = (port == 2) ? stall_mem : stall_if;
      @(negedge clk); #1;
      n++;
    end while (!mem_en && n < 100);
    if (!mem_en) begin
      fail("access_start_timeout", "mem_en never rose");
      return;
    end
    check1("stall_in_request_cycle", prev, 1'b1);
    check1("stall_in_access", (port == 2) ? stall_mem : stall_if, 1'b1);
    if (we) check("mem_wdata", mem_wdata, wdata);
    while (mem_en && a < 100) begin
      check("mem_addr", DW'(mem_addr), DW'(addr));
      check1("mem_we", mem_we, we);
      a++;
      @(negedge clk); #1;
    end
    if (cycles > 0) check("access_cycles", DW'(a), DW'(cycles));
    check1("ack_in_done", (port == 2) ? dm_ack : if_ack, 1'b1);
    check1("stall_low_in_done", (port == 2) ? stall_mem : stall_if, 1'b0);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", DW'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check1("rst_if_ack", if_ack, 1'b0);
    check1("rst_dm_ack", dm_ack, 1'b0);
    check("rst_if_rdata", if_rdata, '0);
    check("rst_dm_rdata", dm_rdata, '0);
    check1("rst_stall_if", stall_if, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk); #1;

    // Single fetch, zero wait states.
    fixed_wait = 0;
    push_job(1, 1'b0, 7'h05, '0);
    watch_access(1, 7'h05, 1'b0, '0, 1);
    wait_idle();

    // Data read with three wait states.
    fixed_wait = 3;
    push_job(2, 1'b0, 7'h10, '0);
    watch_access(2, 7'h10, 1'b0, '0, 4);
    wait_idle();

    // Write leaves dm_rdata at the previous read value.
    fixed_wait = 1;
    push_job(2, 1'b0, 7'h20, '0);
    wait_idle();
    push_job(2, 1'b1, 7'h03, 32'hDEAD_BEEF);
    watch_access(2, 7'h03, 1'b1, 32'hDEAD_BEEF, 2);
    check("dm_rdata_after_write", dm_rdata, 32'h0000_1234);
    wait_idle();
    push_job(2, 1'b0, 7'h03, '0);
    wait_idle();

    // Simultaneous arrival, then sustained contention.
    fixed_wait = 0;
    push_job(1, 1'b0, 7'h11, '0);
    push_job(2, 1'b0, 7'h12, '0);
    wait_idle();
    for (int i = 0; i < 10; i++) push_job(2, 1'b0, AW'(64 + i), '0);
    for (int i = 0; i < 3; i++) push_job(1, 1'b0, AW'(40 + i), '0);
    wait_idle();

    // Asynchronous reset in the middle of a long access.
    fixed_wait = 6;
    push_job(1, 1'b0, 7'h07, '0);
    n = 0;
    while (!mem_en && n < 50) begin @(negedge clk); #1; n++; end
    if (!mem_en) fail("reset_test_start", "access never started");
    @(posedge clk); #3;
    rst_n = 1'b0;
    reset_epoch++;
    #1;
    check1("async_rst_mem_en", mem_en, 1'b0);
    check1("async_rst_mem_we", mem_we, 1'b0);
    check1("async_rst_if_ack", if_ack, 1'b0);
    check1("async_rst_dm_ack", dm_ack, 1'b0);
    check("async_rst_if_rdata", if_rdata, '0);
    fixed_wait = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    wait_idle();
    push_job(2, 1'b1, 7'h50, $urandom);
    wait_idle();

    // Randomized traffic with random wait states.
    fixed_wait = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 3) == 0) push_job(1, 1'b0, AW'($urandom_range(0, 63)), '0);
      if ($urandom_range(0, 2) == 0)
        push_job(2, 1'(($urandom_range(0, 1))), AW'($urandom_range(64, 127)), $urandom);
    end
    wait_idle();

    check("if_exp_drained", DW'(if_exp.size()), '0);
    check("dm_exp_drained", DW'(dm_exp.size()), '0);
    check("grant_exp_drained", DW'(grant_exp.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported, variable-latency unified memory between the five-stage CPU's instruction-fetch port (stage 1) and data-memory port (stage 4). Grants one requester at a time and drives the shared memory for the whole access. Returns read data with a one-cycle acknowledge pulse and generates per-port stall signals that feed the pipeline hold/stall logic. Data-port priority keeps the older instruction moving, and a starvation limit guarantees fetch progress.

## Interface
- AW, 7, word-address width on all ports.
- DW, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while if_req is pending; must be ≥1.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  AW  fetch word address.
- if_rdata  out  DW  fetched word; valid while if_ack=1, holds afterwards.
- if_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata stable until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  read data; valid while dm_ack=1; unchanged by writes.
- dm_ack  out  1  one-cycle completion pulse for data.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  dm_req & ~dm_ack (combinational).
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completes the current access this cycle.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: memory access in flight.
  - DONE: acknowledge cycle.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a grant, register mem_addr, mem_we and mem_wdata from the granted port, and go to ACCESS.
- ACCESS:
  - mem_en=1; mem_we, mem_addr and mem_wdata are held constant.
  - mem_ready=0: stay in ACCESS, with no upper bound on wait.
  - mem_ready=1: capture mem_rdata into the granted port's rdata register (reads only), then go to DONE.
- DONE:
  - The granted port's ack=1; mem_en=0.
  - Always go to IDLE.
  - req is not sampled in DONE, so a held req is never re-granted.
- Arbitration in IDLE:
  - Only dm_req: grant the data port.
  - Only if_req: grant the fetch port.
  - Both, and starve_cnt < STARVE_MAX: grant the data port.
  - Both, and starve_cnt == STARVE_MAX: grant the fetch port.
- Starvation counter, width clog2(STARVE_MAX+1):
  - +1 on a data grant while if_req=1.
  - Cleared on a fetch grant, or on any IDLE cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Writes: mem_we=1 for the whole ACCESS; dm_ack pulses in DONE; dm_rdata keeps its previous value.
- Reset (asynchronous, effective immediately, including mid-ACCESS):
  - state=IDLE; mem_en, mem_we=0; mem_addr, mem_wdata=0.
  - if_ack, dm_ack=0; if_rdata, dm_rdata=0; starve_cnt=0.
  - An aborted access is not acknowledged; requesters re-issue after reset.
- A requester dropping req during ACCESS is illegal; the access still completes and acks.

## Timing
- Request seen in IDLE at edge k:
  - ACCESS in cycle k+1.
  - With mem_ready=1 in cycle k+1, DONE/ack in cycle k+2.
  - Minimum 3 cycles per access, +1 per wait cycle.
- Throughput: at most one access per 3 cycles; back-to-back requests are granted in the IDLE cycle following DONE.
- if_ack and dm_ack are registered and never high together.
- stall_* deassert in the ack cycle, so the pipeline register advances on the edge ending DONE.
- All outputs except stall_* are registered.

## Structure
- Shared package cpu_mem_pkg:
  - state enum {ST_IDLE, ST_ACCESS, ST_DONE}.
  - grant enum {GNT_NONE, GNT_IF, GNT_DM}.
  - Default AW/DW constants.
- Sub-module mem_arb_starve: the saturating starvation counter with inputs dm_grant, if_grant, if_req, idle, and outputs force_if and the count.
- Top level holds the FSM, the grant register, the memory-side registers and the rdata/ack registers.

## Test plan
- Single fetch: if_req=1, if_addr=0x05, mem_ready=1 one cycle after mem_en, mem_rdata=0x8C220010 → mem_addr=0x05 in cycle k+1; if_ack in k+2 with if_rdata=0x8C220010; stall_if high in k, k+1; low in k+2.
- Wait states: dm read at addr 0x10, mem_ready held low 3 cycles → mem_en/mem_addr stable 4 cycles; exactly one dm_ack; dm_rdata=mem_rdata at the ready cycle.
- Write: dm_we=1, addr 0x03, wdata 0xDEADBEEF, prior dm_rdata=0x1234 → mem_we=1 throughout ACCESS; dm_ack pulses; dm_rdata stays 0x1234.
- Contention, STARVE_MAX=4: if_req and dm_req held high continuously, acking each → grant order DM,DM,DM,DM,IF,DM,…; no grant in any DONE cycle.
- Reset mid-ACCESS: assert rst_n=0 while mem_en=1 → mem_en, mem_we, acks drop without a clock edge; no ack after release; a re-issued request completes normally.
- Simultaneous arrival with starve_cnt=0: both req asserted in the same IDLE cycle → data port granted first; fetch granted in the IDLE cycle after dm_ack.
